iop_cm16x40_ctl: RTL and testbench

Sequencing and allocation controller for one 16-entry x 40-bit dual-ported CAM. It owns the entry valid vector and allocates the lowest free entry on request. It arbitrates write, read and lookup requests onto the CAM's one-hot write, read and CAM ports, and returns qualified lookup and read responses at a fixed latency. It sits between the IOP request-tracking logic and the CAM macro instance.

---
 rtl/cm16_ctl_pkg.sv | 36 +++
 rtl/cm16_ctl_penc.sv | 32 +++
 rtl/iop_cm16x40_ctl.sv | 179 +++++++++++++++++
 tb/tb_iop_cm16x40_ctl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm16_ctl_pkg.sv
// Shared constants, helpers and response types for the 16x40 CAM controller.
package cm16_ctl_pkg;

  localparam int NUM_ENT = 16;
  localparam int IDX_W   = 4;
  localparam int DATA_W  = 40;
  localparam int KEY_LSB = 8;

  // Binary index to one-hot wordline.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  // One-hot (or all-zero) vector to binary index; all-zero encodes to 0.
  function automatic logic [3:0] enc16(input logic [15:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r = r | i[3:0];
    end
    return r;
  endfunction

  typedef struct packed {
    logic             vld;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             multi;
  } lkup_rsp_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } rd_rsp_t;

endpackage

// File: rtl/cm16_ctl_penc.sv
// 16-bit lowest-set priority encoder with any / more-than-one outputs.
// MULTI_EN=0 removes the multiple-bit detection and ties multi_o low.
module cm16_ctl_penc
  import cm16_ctl_pkg::*;
#(
  parameter bit MULTI_EN = 1'b1
) (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        any_o,
  output logic        multi_o
);

  logic [15:0] lowest;

  // Isolate the lowest set bit, then encode it.
  always_comb begin
    lowest = vec_i & (~vec_i + 16'd1);
    idx_o  = enc16(lowest);
    any_o  = |vec_i;
  end

  generate
    if (MULTI_EN) begin : g_multi
      // More than one bit set: clearing the lowest still leaves something.
      assign multi_o = |(vec_i & (vec_i - 16'd1));
    end else begin : g_no_multi
      assign multi_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/iop_cm16x40_ctl.sv
// Sequencing / allocation controller for a 16-entry x 40-bit dual-ported CAM.
// Owns the entry valid vector, allocates the lowest free entry, issues
// registered one-hot write/read/lookup commands to the CAM and returns
// lookup and read responses three cycles after grant.
// Optional feature: define CAM16_CTL_MULTIHIT_CHK_EN to compute lkup_multi;
// otherwise lkup_multi is tied 0 and the multi-hit detector is not built.
module iop_cm16x40_ctl #(
  parameter int NUM_ENT = 16
) (
  input  logic               rclk,
  input  logic               rst_l,
  input  logic               alloc_req,
  input  logic [39:0]        alloc_data,
  output logic               alloc_gnt,
  output logic [3:0]         alloc_idx,
  input  logic               dealloc_vld,
  input  logic [3:0]         dealloc_idx,
  output logic               dealloc_err,
  input  logic               lkup_req,
  input  logic [39:8]        lkup_key,
  output logic               lkup_gnt,
  output logic               lkup_rsp_vld,
  output logic               lkup_hit,
  output logic [3:0]         lkup_hit_idx,
  output logic               lkup_multi,
  input  logic               rd_req,
  input  logic [3:0]         rd_idx,
  output logic               rd_gnt,
  output logic               rd_rsp_vld,
  output logic [39:0]        rd_data,
  output logic [NUM_ENT-1:0] valid_vec,
  output logic               full,
  output logic               empty,
  output logic [NUM_ENT-1:0] cam_adr_w,
  output logic [39:0]        cam_din,
  output logic               cam_write_en,
  output logic [NUM_ENT-1:0] cam_adr_r,
  output logic               cam_read_en,
  output logic               cam_lookup_en,
  output logic [39:8]        cam_key,
  input  logic [NUM_ENT-1:0] cam_match,
  input  logic [39:0]        cam_dout
);

  import cm16_ctl_pkg::*;

`ifdef CAM16_CTL_MULTIHIT_CHK_EN
  localparam bit MULTI_EN = 1'b1;
`else
  localparam bit MULTI_EN = 1'b0;
`endif

  // Request/grant handshake: every *_req is sampled each cycle and its *_gnt
  // is a same-cycle combinational answer; a request is taken exactly in a
  // cycle where req and gnt are both high, and nothing is queued on a deny,
  // so the requester must hold or retry the request itself.

  logic [NUM_ENT-1:0] valid_q, valid_d;
  logic               dealloc_err_q;
  logic [NUM_ENT-1:0] cam_adr_w_q, cam_adr_r_q;
  logic [39:0]        cam_din_q;
  logic               cam_write_en_q, cam_read_en_q, cam_lookup_en_q;
  logic [39:8]        cam_key_q;
  logic               lk_vld1_q, lk_vld2_q;
  logic [NUM_ENT-1:0] lk_mask1_q, lk_mask2_q;
  logic               rd_vld1_q, rd_vld2_q;
  lkup_rsp_t          lkup_rsp_q, lkup_rsp_d;
  rd_rsp_t            rd_rsp_q, rd_rsp_d;

  logic [3:0]         free_idx;
  logic               free_any;
  logic               free_multi_unused;
  logic [NUM_ENT-1:0] hit_vec;
  logic [3:0]         hit_idx;
  logic               hit_any;
  logic               hit_multi;
  logic               dealloc_hit;
  logic [NUM_ENT-1:0] alloc_mask, dealloc_mask;

  // Free-entry selection: lowest clear bit of the valid vector.
  cm16_ctl_penc #(.MULTI_EN(1'b0)) u_free_penc (
    .vec_i   (~valid_q),
    .idx_o   (free_idx),
    .any_o   (free_any),
    .multi_o (free_multi_unused)
  );

  // Hit selection on the CAM match vector masked by the piped valid snapshot.
  cm16_ctl_penc #(.MULTI_EN(MULTI_EN)) u_hit_penc (
    .vec_i   (hit_vec),
    .idx_o   (hit_idx),
    .any_o   (hit_any),
    .multi_o (hit_multi)
  );

  // Grants, valid-vector update and response next-state.
  always_comb begin
    full         = ~free_any;
    empty        = ~|valid_q;
    alloc_gnt    = alloc_req & ~full;
    alloc_idx    = free_idx;
    lkup_gnt     = lkup_req;
    rd_gnt       = rd_req & ~(alloc_gnt & (rd_idx == alloc_idx));
    dealloc_hit  = dealloc_vld & valid_q[dealloc_idx];
    alloc_mask   = alloc_gnt ? onehot16(alloc_idx) : '0;
    dealloc_mask = dealloc_hit ? onehot16(dealloc_idx) : '0;
    valid_d      = (valid_q & ~dealloc_mask) | alloc_mask;
    hit_vec      = lk_mask2_q & cam_match & {NUM_ENT{lk_vld2_q}};

    lkup_rsp_d       = '0;
    lkup_rsp_d.vld   = lk_vld2_q;
    lkup_rsp_d.hit   = hit_any;
    lkup_rsp_d.idx   = hit_idx;
    lkup_rsp_d.multi = hit_multi;

    rd_rsp_d      = rd_rsp_q;
    rd_rsp_d.vld  = rd_vld2_q;
    if (rd_vld2_q) rd_rsp_d.data = cam_dout;
  end

  // State, CAM command registers and response pipelines.
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q         <= '0;
      dealloc_err_q   <= 1'b0;
      cam_adr_w_q     <= '0;
      cam_din_q       <= '0;
      cam_write_en_q  <= 1'b0;
      cam_adr_r_q     <= '0;
      cam_read_en_q   <= 1'b0;
      cam_lookup_en_q <= 1'b0;
      cam_key_q       <= '0;
      lk_vld1_q       <= 1'b0;
      lk_vld2_q       <= 1'b0;
      lk_mask1_q      <= '0;
      lk_mask2_q      <= '0;
      rd_vld1_q       <= 1'b0;
      rd_vld2_q       <= 1'b0;
      lkup_rsp_q      <= '0;
      rd_rsp_q        <= '0;
    end else begin
      valid_q         <= valid_d;
      dealloc_err_q   <= dealloc_vld & ~valid_q[dealloc_idx];
      cam_write_en_q  <= alloc_gnt;
      cam_adr_w_q     <= alloc_mask;
      cam_din_q       <= alloc_gnt ? alloc_data : '0;
      cam_read_en_q   <= rd_gnt;
      cam_adr_r_q     <= rd_gnt ? onehot16(rd_idx) : '0;
      cam_lookup_en_q <= lkup_req;
      cam_key_q       <= lkup_req ? lkup_key : '0;
      // Snapshot taken before this cycle's alloc/dealloc lands.
      lk_vld1_q       <= lkup_req;
      lk_mask1_q      <= valid_q;
      lk_vld2_q       <= lk_vld1_q;
      lk_mask2_q      <= lk_mask1_q;
      rd_vld1_q       <= rd_gnt;
      rd_vld2_q       <= rd_vld1_q;
      lkup_rsp_q      <= lkup_rsp_d;
      rd_rsp_q        <= rd_rsp_d;
    end
  end

  assign dealloc_err   = dealloc_err_q;
  assign valid_vec     = valid_q;
  assign cam_adr_w     = cam_adr_w_q;
  assign cam_din       = cam_din_q;
  assign cam_write_en  = cam_write_en_q;
  assign cam_adr_r     = cam_adr_r_q;
  assign cam_read_en   = cam_read_en_q;
  assign cam_lookup_en = cam_lookup_en_q;
  assign cam_key       = cam_key_q;
  assign lkup_rsp_vld  = lkup_rsp_q.vld;
  assign lkup_hit      = lkup_rsp_q.hit;
  assign lkup_hit_idx  = lkup_rsp_q.idx;
  assign lkup_multi    = lkup_rsp_q.multi;
  assign rd_rsp_vld    = rd_rsp_q.vld;
  assign rd_data       = rd_rsp_q.data;

endmodule

// File: tb/tb_iop_cm16x40_ctl.sv
// Directed self-checking bench for iop_cm16x40_ctl with a behavioural CAM
// macro stub (registered match vector and registered read data).
// Honours CAM16_CTL_MULTIHIT_CHK_EN for the expected multi-hit flag.
module tb_iop_cm16x40_ctl;

  // Clock / reset
  logic rclk = 1'b0;
  logic rst_l;
  always #5 rclk = ~rclk;

  logic        alloc_req;
  logic [39:0] alloc_data;
  logic        alloc_gnt;
  logic [3:0]  alloc_idx;
  logic        dealloc_vld;
  logic [3:0]  dealloc_idx;
  logic        dealloc_err;
  logic        lkup_req;
  logic [39:8] lkup_key;
  logic        lkup_gnt;
  logic        lkup_rsp_vld;
  logic        lkup_hit;
  logic [3:0]  lkup_hit_idx;
  logic        lkup_multi;
  logic        rd_req;
  logic [3:0]  rd_idx;
  logic        rd_gnt;
  logic        rd_rsp_vld;
  logic [39:0] rd_data;
  logic [15:0] valid_vec;
  logic        full;
  logic        empty;
  logic [15:0] cam_adr_w;
  logic [39:0] cam_din;
  logic        cam_write_en;
  logic [15:0] cam_adr_r;
  logic        cam_read_en;
  logic        cam_lookup_en;
  logic [39:8] cam_key;
  logic [15:0] cam_match;
  logic [39:0] cam_dout;

`ifdef CAM16_CTL_MULTIHIT_CHK_EN
  localparam logic MULTI_EXP = 1'b1;
`else
  localparam logic MULTI_EXP = 1'b0;
`endif

  iop_cm16x40_ctl #(.NUM_ENT(16)) dut (
    .rclk(rclk), .rst_l(rst_l),
    .alloc_req(alloc_req), .alloc_data(alloc_data),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .dealloc_vld(dealloc_vld), .dealloc_idx(dealloc_idx),
    .dealloc_err(dealloc_err),
    .lkup_req(lkup_req), .lkup_key(lkup_key), .lkup_gnt(lkup_gnt),
    .lkup_rsp_vld(lkup_rsp_vld), .lkup_hit(lkup_hit),
    .lkup_hit_idx(lkup_hit_idx), .lkup_multi(lkup_multi),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt),
    .rd_rsp_vld(rd_rsp_vld), .rd_data(rd_data),
    .valid_vec(valid_vec), .full(full), .empty(empty),
    .cam_adr_w(cam_adr_w), .cam_din(cam_din), .cam_write_en(cam_write_en),
    .cam_adr_r(cam_adr_r), .cam_read_en(cam_read_en),
    .cam_lookup_en(cam_lookup_en), .cam_key(cam_key),
    .cam_match(cam_match), .cam_dout(cam_dout)
  );

  // CAM macro stub: writes and lookups act at the edge ending the command
  // cycle; a lookup compares against pre-write contents.
  logic [39:0] cam_mem [16];
  always @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      cam_match <= '0;
      cam_dout  <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (cam_write_en && cam_adr_w[i]) cam_mem[i] <= cam_din;
        cam_match[i] <= cam_lookup_en && (cam_mem[i][39:8] == cam_key);
        if (cam_read_en && cam_adr_r[i]) cam_dout <= cam_mem[i];
      end
    end
  end

  // Scoreboard counters and checker
  int n_vec     = 0;
  int n_miscmp  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req   = 1'b0;
    alloc_data  = '0;
    dealloc_vld = 1'b0;
    dealloc_idx = '0;
    lkup_req    = 1'b0;
    lkup_key    = '0;
    rd_req      = 1'b0;
    rd_idx      = '0;
  endtask

  task automatic do_dealloc(input logic [3:0] idx);
    dealloc_vld = 1'b1;
    dealloc_idx = idx;
    step();
    dealloc_vld = 1'b0;
  endtask

  task automatic do_alloc(input logic [39:0] data, input logic [3:0] exp_idx);
    alloc_req  = 1'b1;
    alloc_data = data;
    #1;
    check_eq("alloc_gnt", alloc_gnt, 1);
    check_eq("alloc_idx", alloc_idx, exp_idx);
    step();
    alloc_req = 1'b0;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_l = 1'b0;
    repeat (3) step();
    check_eq("rst_valid_vec", valid_vec, 16'h0000);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_lkup_rsp_vld", lkup_rsp_vld, 0);
    check_eq("rst_rd_rsp_vld", rd_rsp_vld, 0);
    check_eq("rst_cam_write_en", cam_write_en, 0);
    check_eq("rst_dealloc_err", dealloc_err, 0);
    rst_l = 1'b1;
    step();

    // Fill all 16 entries, then one more that must be refused.
    for (int i = 0; i < 17; i++) begin
      alloc_req  = 1'b1;
      alloc_data = 40'h100 + i;
      #1;
      if (i < 16) begin
        check_eq("fill_alloc_gnt", alloc_gnt, 1);
        check_eq("fill_alloc_idx", alloc_idx, i);
      end else begin
        check_eq("full_alloc_gnt", alloc_gnt, 0);
        check_eq("full_flag", full, 1);
      end
      step();
      if (i < 16) begin
        check_eq("fill_cam_write_en", cam_write_en, 1);
        check_eq("fill_cam_adr_w", cam_adr_w, 64'h1 << i);
        check_eq("fill_cam_din", cam_din, 40'h100 + i);
      end else begin
        check_eq("full_cam_write_en", cam_write_en, 0);
        check_eq("full_cam_adr_w", cam_adr_w, 16'h0000);
      end
    end
    alloc_req = 1'b0;
    check_eq("fill_valid_vec", valid_vec, 16'hFFFF);
    check_eq("fill_empty", empty, 0);
    step();

    // Array visibility: lookup with the alloc misses, one cycle later hits.
    do_dealloc(4'd3);
    check_eq("free3_valid_vec", valid_vec, 16'hFFF7);
    check_eq("free3_dealloc_err", dealloc_err, 0);
    alloc_req  = 1'b1;
    alloc_data = 40'h12_3456_7800;
    lkup_req   = 1'b1;
    lkup_key   = 32'h1234_5678;
    #1;
    check_eq("vis_alloc_idx", alloc_idx, 3);
    check_eq("vis_lkup_gnt", lkup_gnt, 1);
    step();
    alloc_req = 1'b0;
    step();
    lkup_req = 1'b0;
    check_eq("vis_early_rsp_vld", lkup_rsp_vld, 0);
    step();
    check_eq("vis_same_rsp_vld", lkup_rsp_vld, 1);
    check_eq("vis_same_hit", lkup_hit, 0);
    step();
    check_eq("vis_next_rsp_vld", lkup_rsp_vld, 1);
    check_eq("vis_next_hit", lkup_hit, 1);
    check_eq("vis_next_idx", lkup_hit_idx, 3);
    check_eq("vis_next_multi", lkup_multi, 0);
    step();
    check_eq("vis_idle_rsp_vld", lkup_rsp_vld, 0);

    // Duplicate key in entries 2 and 5.
    do_dealloc(4'd2);
    do_dealloc(4'd5);
    check_eq("free25_valid_vec", valid_vec, 16'hFFDB);
    do_alloc(40'hAA_BBCC_DD00, 4'd2);
    do_alloc(40'hAA_BBCC_DD00, 4'd5);
    lkup_req = 1'b1;
    lkup_key = 32'hAABB_CCDD;
    step();
    lkup_req = 1'b0;
    step();
    step();
    check_eq("dup_rsp_vld", lkup_rsp_vld, 1);
    check_eq("dup_hit", lkup_hit, 1);
    check_eq("dup_idx", lkup_hit_idx, 2);
    check_eq("dup_multi", lkup_multi, MULTI_EXP);

    // Free 2, lookup the same key, then free 2 again.
    dealloc_vld = 1'b1;
    dealloc_idx = 4'd2;
    step();
    check_eq("free2_dealloc_err", dealloc_err, 0);
    dealloc_vld = 1'b0;
    lkup_req    = 1'b1;
    lkup_key    = 32'hAABB_CCDD;
    step();
    lkup_req    = 1'b0;
    dealloc_vld = 1'b1;
    dealloc_idx = 4'd2;
    step();
    dealloc_vld = 1'b0;
    check_eq("refree2_dealloc_err", dealloc_err, 1);
    check_eq("refree2_valid_vec", valid_vec, 16'hFFFB);
    step();
    check_eq("refree2_err_pulse_end", dealloc_err, 0);
    check_eq("single_rsp_vld", lkup_rsp_vld, 1);
    check_eq("single_hit", lkup_hit, 1);
    check_eq("single_idx", lkup_hit_idx, 5);
    check_eq("single_multi", lkup_multi, 0);

    // Read/write wordline conflict on entry 7, retry, then pipelined read.
    do_dealloc(4'd7);
    do_alloc(40'h00_0000_0055, 4'd2);
    alloc_req  = 1'b1;
    alloc_data = 40'h77_6655_4433;
    rd_req     = 1'b1;
    rd_idx     = 4'd7;
    #1;
    check_eq("conf_alloc_idx", alloc_idx, 7);
    check_eq("conf_rd_gnt", rd_gnt, 0);
    step();
    alloc_req = 1'b0;
    #1;
    check_eq("retry_rd_gnt", rd_gnt, 1);
    check_eq("conf_cam_read_en", cam_read_en, 0);
    step();
    rd_idx = 4'd0;
    check_eq("retry_cam_read_en", cam_read_en, 1);
    check_eq("retry_cam_adr_r", cam_adr_r, 16'h0080);
    step();
    rd_req = 1'b0;
    check_eq("rd_early_rsp_vld", rd_rsp_vld, 0);
    step();
    check_eq("rd7_rsp_vld", rd_rsp_vld, 1);
    check_eq("rd7_data", rd_data, 40'h77_6655_4433);
    step();
    check_eq("rd0_rsp_vld", rd_rsp_vld, 1);
    check_eq("rd0_data", rd_data, 40'h00_0000_0100);
    step();
    check_eq("rd_idle_rsp_vld", rd_rsp_vld, 0);

    // Reset one cycle after a lookup grant kills the response.
    lkup_req = 1'b1;
    lkup_key = 32'h1234_5678;
    step();
    lkup_req = 1'b0;
    rst_l    = 1'b0;
    #1;
    check_eq("mid_rst_valid_vec", valid_vec, 16'h0000);
    check_eq("mid_rst_empty", empty, 1);
    step();
    rst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("mid_rst_no_rsp", lkup_rsp_vld, 0);
      step();
    end
    check_eq("post_rst_valid_vec", valid_vec, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
